// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one product/quotient bit per cycle.
// Define MULDIV_MADD_EN to build the MADD/MSUB accumulate datapath (ops 100-111).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_fam;
  logic [WIDTH-1:0] r_op1, r_mag2, r_upper, r_lower;
  logic             r_neg_q, r_neg_r;
  logic             r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_accept, w_is_div, w_div_zero;
  logic             w_neg1, w_neg2;
  logic [WIDTH-1:0] w_mag1, w_mag2;
  logic [WIDTH:0]   w_add, w_trial;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_is_div = ~r_fam[1] & r_fam[0];

  // Signed ops (op[0]=0) run the engine on magnitudes; signs are re-applied in FIX.
  assign w_neg1 = ~op[0] & op1[WIDTH-1];
  assign w_neg2 = ~op[0] & op2[WIDTH-1];
  assign w_mag1 = w_neg1 ? -op1 : op1;
  assign w_mag2 = w_neg2 ? -op2 : op2;

  assign w_add   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_mag2} : '0);
  assign w_trial = {r_upper, r_lower[WIDTH-1]} - {1'b0, r_mag2};

  assign w_prod     = {r_upper, r_lower};
  assign w_prod_s   = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_neg_q ? -r_lower : r_lower;
  assign w_rem      = r_neg_r ? -r_upper : r_upper;
  assign w_div_zero = w_is_div && (r_mag2 == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (r_state == S_FIX);
      r_div_zero <= (r_state == S_FIX) && w_div_zero;
      if (!r_busy) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
      // FIX is always busy, so this never collides with an MTHI/MTLO write.
      if (r_state == S_FIX) begin
        if (w_is_div) begin
          if (w_div_zero) begin
            r_hi <= r_op1;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end else if (!r_fam[1]) begin
          {r_hi, r_lo} <= w_prod_s;
        end else begin
`ifdef MULDIV_MADD_EN
          if (r_fam[0]) {r_hi, r_lo} <= {r_hi, r_lo} - w_prod_s;
          else          {r_hi, r_lo} <= {r_hi, r_lo} + w_prod_s;
`endif
        end
      end
    end
  end

  // NOTE: engine registers are loaded on every accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cnt   <= CW'(WIDTH - 1);
      r_fam   <= op[2:1];
      r_op1   <= op1;
      r_mag2  <= w_mag2;
      r_upper <= '0;
      r_lower <= w_mag1;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_is_div) begin
        // Restoring step: bit WIDTH of the trial difference is set when it went negative.
        r_upper <= w_trial[WIDTH] ? {r_upper[WIDTH-2:0], r_lower[WIDTH-1]} : w_trial[WIDTH-1:0];
        r_lower <= {r_lower[WIDTH-2:0], ~w_trial[WIDTH]};
      end else begin
        r_upper <= w_add[WIDTH:1];
        r_lower <= {w_add[0], r_lower[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32; honours MULDIV_MADD_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] op1 = '0, op2 = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MADDU = 3'b101, OP_MSUB = 3'b110;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1), .op2(op2),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Issues one op from the current cycle and returns once done is seen (or the bound expires).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic dz);
    op = o; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op1 = 32'hDEAD_BEEF; op2 = 32'h0BAD_F00D; op = 3'b111;
    lat = 0; dz = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin lat = i; dz = div_zero; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int lat, bc; logic dz;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat, bc, dz);
    checks++; if (lat !== 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    checks++; if (bc !== 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, lat, bc, dz);
    checks++; if ({hi, lo} !== 64'd12) begin failures++; $display("FAIL mult_negneg got=%h%h exp=12", hi, lo); end
  endtask

  task automatic test_multu();
    int lat, bc; logic dz;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dz);
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_div();
    int lat, bc; logic dz;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, dz);
    checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hi); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_neg_dz got=%b exp=0", dz); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bc, dz);
    checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin failures++; $display("FAIL div_negdivisor got=%h_%h exp=00000001_fffffffd", hi, lo); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
    checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_divu();
    int lat, bc; logic dz;
    run_op(OP_DIVU, 32'd7, 32'd2, lat, bc, dz);
    checks++; if (lo !== 32'd3) begin failures++; $display("FAIL divu_lo got=%h exp=3", lo); end
    checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_hi got=%h exp=1", hi); end
    run_op(OP_DIVU, 32'd5, 32'd0, lat, bc, dz);
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_lo got=%h exp=ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin failures++; $display("FAIL divz_hi got=%h exp=5", hi); end
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL divz_flag got=%b exp=1", dz); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL divz_latency got=%0d exp=33", lat); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL divz_flag_clear got=%b exp=0", div_zero); end
  endtask

  task automatic test_ignore_busy();
    int n_done, lat;
    logic [31:0] got_hi, got_lo, mid_hi;
    op = OP_MULTU; op1 = 32'd5; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; lat = 0; got_hi = '0; got_lo = '0; mid_hi = '0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        start = 1'b1; op = OP_DIVU; op1 = 32'd9; op2 = 32'd0; mthi = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(posedge clk); #1;
      if (i == 20) mid_hi = hi;
      if (done) begin
        n_done++;
        if (lat == 0) begin lat = i; got_hi = hi; got_lo = lo; end
      end
    end
    start = 1'b0; mthi = 1'b0;
    checks++; if (mid_hi !== 32'd5) begin failures++; $display("FAIL ignore_mthi_hold got=%h exp=5", mid_hi); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    checks++; if ({got_hi, got_lo} !== 64'd35) begin failures++; $display("FAIL ignore_result got=%h_%h exp=0_23", got_hi, got_lo); end
  endtask

  task automatic test_mtx();
    mtlo = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++; if (lo !== 32'hABCD) begin failures++; $display("FAIL mtlo_lo got=%h exp=abcd", lo); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL mtlo_hi got=%h exp=0", hi); end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++; if ({hi, lo} !== {2{32'h5A5A_5A5A}}) begin failures++; $display("FAIL mt_both got=%h_%h exp=5a5a5a5a_5a5a5a5a", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    op = OP_MULTU; op1 = 32'd3; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic dz;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, dz);
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL b2b_first got=%h_%h exp=2_e", hi, lo); end
    run_op(OP_MULTU, 32'd6, 32'd7, lat, bc, dz);
    checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    checks++; if (bc !== 33) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=33", bc); end
    checks++; if ({hi, lo} !== 64'd42) begin failures++; $display("FAIL b2b_second got=%h_%h exp=0_2a", hi, lo); end
  endtask

  task automatic test_madd();
    int lat, bc; logic dz;
    logic [63:0] exp1, exp2;
`ifdef MULDIV_MADD_EN
    exp1 = 64'h0000_0001_0000_0000;
    exp2 = 64'h0000_0000_FFFF_FFFF;
`else
    exp1 = 64'h0000_0000_FFFF_FFFF;
    exp2 = 64'h0000_0000_FFFF_FFFF;
`endif
    mthi = 1'b1; wdata = 32'h0;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mtlo = 1'b0;
    run_op(OP_MADDU, 32'd1, 32'd1, lat, bc, dz);
    checks++; if (lat !== 33) begin failures++; $display("FAIL maddu_latency got=%0d exp=33", lat); end
    checks++; if ({hi, lo} !== exp1) begin failures++; $display("FAIL maddu_result got=%h_%h exp=%h", hi, lo, exp1); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL maddu_dz got=%b exp=0", dz); end
    run_op(OP_MSUB, 32'd1, 32'd1, lat, bc, dz);
    checks++; if (lat !== 33) begin failures++; $display("FAIL msub_latency got=%0d exp=33", lat); end
    checks++; if ({hi, lo} !== exp2) begin failures++; $display("FAIL msub_result got=%h_%h exp=%h", hi, lo, exp2); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_ignore_busy();
    test_mtx();
    test_reset_mid();
    test_back_to_back();
    test_madd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
